three_parallel_sequencer: RTL and testbench

- Scheduler between a 1-sample/cycle serial stream and the 3-parallel pipelined FIR datapath.
- Groups serial input samples into 3-sample blocks and issues each block with a one-cycle clock-enable pulse (filt_en).
- Tracks blocks in flight through the filter pipeline, captures the three results into an output buffer, and serializes them with valid/ready backpressure.

---
 rtl/three_parallel_pkg.sv | 30 +++
 rtl/three_parallel_obuf.sv | 66 ++++++
 rtl/three_parallel_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_three_parallel_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/three_parallel_pkg.sv
// Shared types and defaults for the 3-parallel FIR sequencer.
// The optional pipeline flush is built when SEQ_FLUSH_EN is defined.
package three_parallel_pkg;

    localparam int DW_DEF         = 16;
    localparam int OW_DEF         = 64;
    localparam int LATENCY_DEF    = 4;
    localparam int OBUF_DEPTH_DEF = 4;

    typedef logic signed [DW_DEF-1:0] sample_t;
    typedef logic signed [OW_DEF-1:0] result_t;

    typedef struct packed {
        result_t r1;
        result_t r2;
        result_t r3;
    } blk_res_t;

    // Serializer phase walks dout1 -> dout2 -> dout3 and wraps.
    function automatic logic [1:0] phase_next(input logic [1:0] phase);
        logic [1:0] nxt;
        case (phase)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/three_parallel_obuf.sv
// Output block buffer: synchronous FIFO of 3-result entries with
// simultaneous push/pop and an occupancy count used for credit.
module three_parallel_obuf
    import three_parallel_pkg::*;
#(
    parameter int  DEPTH   = OBUF_DEPTH_DEF,
    parameter type entry_t = blk_res_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  entry_t  din,
    input  logic    pop,
    output entry_t  dout,
    output logic [AW:0] occ,
    output logic    empty
);

    entry_t          mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     occ_r;
    logic            do_push_s;
    logic            do_pop_s;

    // Guard the handshakes so a misuse can never corrupt the pointers.
    always_comb begin
        do_pop_s  = pop && (occ_r != '0);
        if (occ_r != (AW+1)'(DEPTH)) begin
            do_push_s = push;
        end else begin
            do_push_s = push && do_pop_s;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   occ_r <= occ_r + (AW+1)'(1);
                2'b01:   occ_r <= occ_r - (AW+1)'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign occ   = occ_r;
    assign empty = (occ_r == '0);

endmodule

// File: rtl/three_parallel_sequencer.sv
// Scheduler between a serial sample stream and a 3-parallel FIR pipeline:
// gathers 3-sample blocks, issues them with a filt_en pulse, tracks blocks
// in flight, buffers results and serializes them with valid/ready.
// Define SEQ_FLUSH_EN to add the flush input that drains the pipeline.
module three_parallel_sequencer
    import three_parallel_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int OW         = OW_DEF,
    parameter int LATENCY    = LATENCY_DEF,
    parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] filt_din1,
    output logic signed [DW-1:0] filt_din2,
    output logic signed [DW-1:0] filt_din3,
    output logic                 filt_en,
    input  logic signed [OW-1:0] filt_dout1,
    input  logic signed [OW-1:0] filt_dout2,
    input  logic signed [OW-1:0] filt_dout3,
    output logic signed [OW-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
`ifdef SEQ_FLUSH_EN
    ,
    input  logic                 flush
`endif
);

    localparam int OCW = $clog2(OBUF_DEPTH) + 1;

    typedef struct packed {
        logic signed [OW-1:0] r1;
        logic signed [OW-1:0] r2;
        logic signed [OW-1:0] r3;
    } blk_t;

    logic [1:0]           count_r;
    logic signed [DW-1:0] slot0_r;
    logic signed [DW-1:0] slot1_r;
    logic signed [DW-1:0] slot2_r;
    logic [LATENCY-1:0]   vpipe_r;
    logic [1:0]           phase_r;

    logic                 credit_s;
    logic                 real_s;
    logic                 bubble_s;
    logic                 issue_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 empty_s;
    logic [OCW-1:0]       occ_s;
    blk_t                 push_blk_s;
    blk_t                 head_s;

    // Credit: buffered blocks plus tagged blocks in flight must leave room.
    always_comb begin
        if ((32'(occ_s) + 32'($countones(vpipe_r))) < 32'(OBUF_DEPTH)) begin
            credit_s = 1'b1;
        end else begin
            credit_s = 1'b0;
        end
    end

    // Decide whether this cycle issues a real block or a flush bubble.
    always_comb begin
        real_s   = 1'b0;
        bubble_s = 1'b0;
`ifdef SEQ_FLUSH_EN
        if (credit_s && (count_r == 2'd3)) begin
            real_s = 1'b1;
        end else if (credit_s && flush && (count_r != 2'd0)) begin
            real_s = 1'b1;
        end else if (credit_s && flush && (vpipe_r != '0)) begin
            bubble_s = 1'b1;
        end else begin
            real_s   = 1'b0;
            bubble_s = 1'b0;
        end
`else
        if (credit_s && (count_r == 2'd3)) begin
            real_s = 1'b1;
        end else begin
            real_s = 1'b0;
        end
`endif
    end

    assign issue_s = real_s | bubble_s;
    assign filt_en = issue_s;

    // Input handshake: room in the gather slots, or the slots empty this cycle.
    always_comb begin
`ifdef SEQ_FLUSH_EN
        if (flush) begin
            in_ready = 1'b0;
        end else if ((count_r < 2'd3) || issue_s) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
`else
        if ((count_r < 2'd3) || issue_s) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
`endif
    end

    assign accept_s = in_valid && in_ready;

    // Block samples to the filter; unfilled slots read as zero when flushing.
    always_comb begin
`ifdef SEQ_FLUSH_EN
        filt_din1 = (count_r > 2'd0) ? slot0_r : '0;
        filt_din2 = (count_r > 2'd1) ? slot1_r : '0;
        filt_din3 = (count_r > 2'd2) ? slot2_r : '0;
`else
        filt_din1 = slot0_r;
        filt_din2 = slot1_r;
        filt_din3 = slot2_r;
`endif
    end

    // Gather slots and fill count; an accept during issue starts the next block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= 2'd0;
            slot0_r <= '0;
            slot1_r <= '0;
            slot2_r <= '0;
        end else if (issue_s) begin
            if (accept_s) begin
                slot0_r <= in_data;
                count_r <= 2'd1;
            end else begin
                count_r <= 2'd0;
            end
        end else if (accept_s) begin
            case (count_r)
                2'd0:    slot0_r <= in_data;
                2'd1:    slot1_r <= in_data;
                2'd2:    slot2_r <= in_data;
                default: slot2_r <= slot2_r;
            endcase
            count_r <= count_r + 2'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // In-flight tags advance only with the filter clock-enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe_r <= '0;
        end else if (issue_s) begin
            vpipe_r <= (vpipe_r << 1) | LATENCY'(real_s);
        end else begin
            vpipe_r <= vpipe_r;
        end
    end

    assign push_s     = issue_s && vpipe_r[LATENCY-1];
    assign push_blk_s = '{r1: filt_dout1, r2: filt_dout2, r3: filt_dout3};
    assign pop_s      = out_valid && out_ready && (phase_r == 2'd2);

    three_parallel_obuf #(
        .DEPTH   (OBUF_DEPTH),
        .entry_t (blk_t)
    ) u_obuf (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (push_blk_s),
        .pop   (pop_s),
        .dout  (head_s),
        .occ   (occ_s),
        .empty (empty_s)
    );

    assign out_valid = !empty_s;

    // Serializer phase moves only on an accepted output beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_r <= 2'd0;
        end else if (out_valid && out_ready) begin
            phase_r <= phase_next(phase_r);
        end else begin
            phase_r <= phase_r;
        end
    end

    // Select the current result of the head block.
    always_comb begin
        if (empty_s) begin
            out_data = '0;
        end else begin
            case (phase_r)
                2'd0:    out_data = head_s.r1;
                2'd1:    out_data = head_s.r2;
                2'd2:    out_data = head_s.r3;
                default: out_data = '0;
            endcase
        end
    end

    assign busy = (count_r != 2'd0) || (vpipe_r != '0) || !empty_s;

endmodule

// File: tb/tb_three_parallel_sequencer.sv
// Self-checking bench: identity-stub filter, queue-based reference model.
module tb_three_parallel_sequencer;

    localparam int DW    = 16;
    localparam int OW    = 64;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [DW-1:0] filt_din1, filt_din2, filt_din3;
    logic filt_en;
    logic signed [OW-1:0] filt_dout1, filt_dout2, filt_dout3;
    logic signed [OW-1:0] out_data;
    logic out_valid;
    logic out_ready = 1'b0;
    logic busy;
`ifdef SEQ_FLUSH_EN
    logic flush = 1'b0;
`endif

    always #5 clk = ~clk;

    three_parallel_sequencer #(
        .DW(DW), .OW(OW), .LATENCY(LAT), .OBUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .filt_din1(filt_din1), .filt_din2(filt_din2), .filt_din3(filt_din3),
        .filt_en(filt_en),
        .filt_dout1(filt_dout1), .filt_dout2(filt_dout2), .filt_dout3(filt_dout3),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
`ifdef SEQ_FLUSH_EN
        , .flush(flush)
`endif
    );

    // Identity filter stub: LAT enable-gated stages, reset with the DUT.
    logic signed [OW-1:0] s1 [LAT];
    logic signed [OW-1:0] s2 [LAT];
    logic signed [OW-1:0] s3 [LAT];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                s1[i] <= '0; s2[i] <= '0; s3[i] <= '0;
            end
        end else if (filt_en) begin
            s1[0] <= OW'(filt_din1);
            s2[0] <= OW'(filt_din2);
            s3[0] <= OW'(filt_din3);
            for (int i = 1; i < LAT; i++) begin
                s1[i] <= s1[i-1]; s2[i] <= s2[i-1]; s3[i] <= s3[i-1];
            end
        end
    end
    assign filt_dout1 = s1[LAT-1];
    assign filt_dout2 = s2[LAT-1];
    assign filt_dout3 = s3[LAT-1];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [15:0] d);
        return {{48{d[15]}}, d};
    endfunction

    // Reference model: samples waiting to be issued, results awaiting output.
    logic [63:0] pend_q[$];
    logic [63:0] exp_q[$];
    int accepted = 0;
    int emitted  = 0;
    int en_count = 0;
    logic prev_stall = 1'b0;
    logic [63:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                check_val("hold_valid", 64'(out_valid), 64'd1);
                check_val("hold_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (filt_en) begin
                logic [63:0] b [3];
                en_count++;
                if (pend_q.size() >= 3) begin
                    for (int k = 0; k < 3; k++) b[k] = pend_q.pop_front();
                    check_val("din1", 64'(filt_din1), b[0]);
                    check_val("din2", 64'(filt_din2), b[1]);
                    check_val("din3", 64'(filt_din3), b[2]);
                    for (int k = 0; k < 3; k++) exp_q.push_back(b[k]);
                end
`ifdef SEQ_FLUSH_EN
                else if (flush && pend_q.size() > 0) begin
                    for (int k = 0; k < 3; k++) b[k] = (pend_q.size() > 0) ? pend_q.pop_front() : 64'd0;
                    check_val("pad_din1", 64'(filt_din1), b[0]);
                    check_val("pad_din2", 64'(filt_din2), b[1]);
                    check_val("pad_din3", 64'(filt_din3), b[2]);
                    for (int k = 0; k < 3; k++) exp_q.push_back(b[k]);
                end else if (flush) begin
                    check_val("bubble_din", 64'({filt_din1, filt_din2, filt_din3}), 64'd0);
                end
`endif
                else begin
                    check_val("en_without_block", 64'(pend_q.size()), 64'd3);
                end
            end
            if (in_valid && in_ready) begin
                pend_q.push_back(sx(in_data));
                accepted++;
            end
            if (out_valid && out_ready) begin
                emitted++;
                if (exp_q.size() == 0) check_val("out_unexpected", 64'(exp_q.size()), 64'd1);
                else check_val("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
`ifdef SEQ_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        pend_q.delete();
        exp_q.delete();
        accepted = 0; emitted = 0; en_count = 0; prev_stall = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        int en_seen;
        int rdy_low;
        // Reset state with the clock running.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_filt_en", 64'(filt_en), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_out_data", out_data, 64'd0);
        check_val("rst_din", 64'({filt_din1, filt_din2, filt_din3}), 64'd0);
        rst = 1'b1;

        // Gather 1,2,3 then issue on the following cycle.
        step(1'b1, 16'd1, 1'b1);
        check_val("gather_no_en1", 64'(filt_en), 64'd0);
        step(1'b1, 16'd2, 1'b1);
        check_val("gather_no_en2", 64'(filt_en), 64'd0);
        step(1'b1, 16'd3, 1'b1);
        check_val("issue_en", 64'(filt_en), 64'd1);
        check_val("issue_din1", 64'(filt_din1), 64'd1);
        check_val("issue_din2", 64'(filt_din2), 64'd2);
        check_val("issue_din3", 64'(filt_din3), 64'd3);

        // Continuous input: a pulse every third cycle, never back-pressured.
        en_seen = 0; rdy_low = 0;
        for (int i = 0; i < 12; i++) begin
            if (filt_en) en_seen++;
            if (!in_ready) rdy_low++;
            step(1'b1, 16'(4 + i), 1'b1);
        end
        check_val("cont_en_pulses", 64'(en_seen), 64'd4);
        check_val("cont_ready_low", 64'(rdy_low), 64'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 16'd0, 1'b1);
        check_val("lat_emitted", 64'(emitted), 64'(3 * (15 / 3 - LAT)));
        check_val("lat_busy_pending", 64'(busy), 64'd1);
        check_val("lat_out_idle", 64'(out_valid), 64'd0);

        // Backpressure: output blocked fills exactly DEPTH blocks of credit.
        do_reset();
        for (int i = 0; i < 30; i++) step(1'b1, 16'($urandom), 1'b0);
        check_val("bp_accepted", 64'(accepted), 64'(3 * DEPTH + 3));
        check_val("bp_issued", 64'(en_count), 64'(DEPTH));
        check_val("bp_in_ready", 64'(in_ready), 64'd0);
        check_val("bp_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 40; i++) step(1'b0, 16'd0, 1'b1);
        check_val("bp_emitted", 64'(emitted), 64'(3 * ((3 * DEPTH + 3) / 3 - LAT)));

        // Output stalls mid-block with ready pattern 1,0,0,1.
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 16'($urandom), 1'b1);
        for (int i = 0; i < 40; i++) step(1'b0, 16'd0, (i % 4 == 0) || (i % 4 == 3));
        check_val("stall_emitted", 64'(emitted), 64'(3 * (12 / 3 - LAT)));

        // Random traffic, then drain what the pipeline can release.
        do_reset();
        for (int i = 0; i < 1500; i++)
            step(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0);
        for (int i = 0; i < 80; i++) step(1'b0, 16'd0, 1'b1);
        check_val("rand_emitted", 64'(emitted), 64'(3 * (accepted / 3 - LAT)));
        check_val("rand_left", 64'(exp_q.size()), 64'(3 * LAT));

        // Asynchronous reset while results are being presented.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 16'($urandom), 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 16'd0, 1'b0);
        check_val("mid_pre_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_val("mid_out_valid", 64'(out_valid), 64'd0);
        check_val("mid_in_ready", 64'(in_ready), 64'd1);
        check_val("mid_busy", 64'(busy), 64'd0);
        check_val("mid_out_data", out_data, 64'd0);
        check_val("mid_filt_en", 64'(filt_en), 64'd0);

`ifdef SEQ_FLUSH_EN
        // Flush: 7 samples, partial block padded, pipeline drained by bubbles.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 16'(i + 1), 1'b1);
        flush = 1'b1;
        in_valid = 1'b1;
        #1;
        check_val("flush_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 100 && busy; i++) step(1'b1, 16'd0, 1'b1);
        check_val("flush_busy", 64'(busy), 64'd0);
        check_val("flush_emitted", 64'(emitted), 64'd9);
        flush = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
